// File: rtl/display_scan_controller_if.sv
// Load handshake and display drive bundle for display_scan_controller.
// Registered outputs; load_ready low while a shadow word is pending.
interface display_scan_controller_if;
    logic        enable;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  digit_code;
    logic [3:0]  an;
    logic [1:0]  digit_sel;
    logic        frame_done;

    modport master (
        output enable, load_valid, load_data,
        input  load_ready, digit_code, an, digit_sel, frame_done
    );

    modport slave (
        input  enable, load_valid, load_data,
        output load_ready, digit_code, an, digit_sel, frame_done
    );
endinterface

// File: rtl/display_scan_controller.sv
// 4-digit seven-segment scan with shadow-buffered load; outputs registered, 1-cycle latency from enable.
// load_ready drops while a word is pending until the frame boundary; SCAN_DEADTIME_EN adds blanking slots.
module display_scan_controller #(
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    display_scan_controller_if.slave   bus
);
    localparam int CNT_N = (CLK_DIV > DEAD_CYCLES) ? CLK_DIV : DEAD_CYCLES;
    localparam int CW    = $clog2(CNT_N);
    localparam logic [CW-1:0] SHOW_LAST = CW'(CLK_DIV - 1);
`ifdef SCAN_DEADTIME_EN
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
`endif

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_DEAD} state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     dbuf_q, dbuf_d;
    logic [15:0]     shadow_q, shadow_d;
    logic            pend_q, pend_d;
    logic [3:0]      an_q, an_d;
    logic [3:0]      code_q, code_d;
    logic            fd_q, fd_d;
    logic            boundary;
    logic            accept;

    assign accept = bus.load_valid && !pend_q;

`ifdef SCAN_DEADTIME_EN
    assign boundary = (state_q == S_DEAD) && (idx_q == 2'd3) && (cnt_q == DEAD_LAST);
`else
    assign boundary = (state_q == S_SHOW) && (idx_q == 2'd3) && (cnt_q == SHOW_LAST);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= '0;
            dbuf_q   <= 16'h0000;
            shadow_q <= 16'h0000;
            pend_q   <= 1'b0;
            an_q     <= 4'hF;
            code_q   <= 4'h0;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dbuf_q   <= dbuf_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            an_q     <= an_d;
            code_q   <= code_d;
            fd_q     <= fd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q + CW'(1);
        dbuf_d   = dbuf_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;

        if (!bus.enable) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_SHOW;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
                S_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_d = '0;
`ifdef SCAN_DEADTIME_EN
                        state_d = S_DEAD;
`else
                        idx_d   = idx_q + 2'd1;
`endif
                    end
                end
`ifdef SCAN_DEADTIME_EN
                S_DEAD: begin
                    if (cnt_q == DEAD_LAST) begin
                        state_d = S_SHOW;
                        idx_d   = idx_q + 2'd1;
                        cnt_d   = '0;
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end

        // A word offered on the boundary cycle bypasses the shadow entirely.
        if (accept) begin
            if (boundary) begin
                dbuf_d = bus.load_data;
            end else begin
                shadow_d = bus.load_data;
                pend_d   = 1'b1;
            end
        end else if (pend_q && (boundary || state_q == S_IDLE)) begin
            dbuf_d = shadow_q;
            pend_d = 1'b0;
        end
    end

    // Outputs are precomputed from the next state so they register alongside it.
    always_comb begin
        an_d   = 4'hF;
        code_d = 4'h0;
        if (state_d == S_SHOW) begin
            an_d   = ~(4'b0001 << idx_d);
            code_d = dbuf_d[{idx_d, 2'b00} +: 4];
        end
`ifdef SCAN_DEADTIME_EN
        fd_d = (state_d == S_DEAD) && (idx_d == 2'd3) && (cnt_d == DEAD_LAST);
`else
        fd_d = (state_d == S_SHOW) && (idx_d == 2'd3) && (cnt_d == SHOW_LAST);
`endif
    end

    assign bus.an         = an_q;
    assign bus.digit_code = code_q;
    assign bus.digit_sel  = idx_q;
    assign bus.frame_done = fd_q;
    assign bus.load_ready = ~pend_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized scoreboard bench for display_scan_controller against a slot-arithmetic reference model.
module tb_display_scan_controller;
    localparam int CD = 4;
    localparam int DC = 2;
`ifdef SCAN_DEADTIME_EN
    localparam int DP = DC;
`else
    localparam int DP = 0;
`endif
    localparam int P = CD + DP;
    localparam int F = 4 * P;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    display_scan_controller_if bus();

    display_scan_controller #(.CLK_DIV(CD), .DEAD_CYCLES(DC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] code;
        logic [1:0] sel;
        logic       fd;
        logic       rdy;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   sb_on = 1'b0;

    bit          m_scan;
    int          m_t;
    logic [15:0] m_buf;
    logic [15:0] m_shad;
    bit          m_pend;

    function automatic obs_t sample();
        return {bus.an, bus.digit_code, bus.digit_sel, bus.frame_done, bus.load_ready};
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t ex);
        n_cmp++;
        if (act !== ex) begin
            n_bad++;
            $display("FAIL %s @%0t: got an=%b code=%h sel=%0d fd=%b rdy=%b, want an=%b code=%h sel=%0d fd=%b rdy=%b",
                     name, $time, act.an, act.code, act.sel, act.fd, act.rdy,
                     ex.an, ex.code, ex.sel, ex.fd, ex.rdy);
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        int   pos;
        int   d;
        int   w;
        o = '{an: 4'hF, code: 4'h0, sel: 2'd0, fd: 1'b0, rdy: !m_pend};
        if (m_scan) begin
            pos   = m_t % F;
            d     = pos / P;
            w     = pos % P;
            o.sel = d[1:0];
            o.fd  = (pos == F - 1);
            if (w < CD) begin
                o.an   = ~(4'b0001 << d);
                o.code = m_buf[4*d +: 4];
            end
        end
        return o;
    endfunction

    task automatic model_step(input logic e, input logic lv, input logic [15:0] ld);
        bit bnd;
        bit acc;
        bnd = m_scan && ((m_t % F) == F - 1);
        acc = lv && !m_pend;
        if (acc && bnd) begin
            m_buf = ld;
        end else if (acc) begin
            m_shad = ld;
            m_pend = 1'b1;
        end else if (m_pend && (bnd || !m_scan)) begin
            m_buf  = m_shad;
            m_pend = 1'b0;
        end
        if (!e) begin
            m_scan = 1'b0;
            m_t    = 0;
        end else if (m_scan) begin
            m_t++;
        end else begin
            m_scan = 1'b1;
            m_t    = 0;
        end
    endtask

    task automatic do_cycle(input logic e, input logic lv, input logic [15:0] ld);
        bus.enable     = e;
        bus.load_valid = lv;
        bus.load_data  = ld;
        @(posedge clk);
        model_step(e, lv, ld);
        exp_q.push_back(model_obs());
        #1;
    endtask

    task automatic do_reset(input string name);
        obs_t rst_exp;
        rst_exp = '{an: 4'hF, code: 4'h0, sel: 2'd0, fd: 1'b0, rdy: 1'b1};
        sb_on = 1'b0;
        exp_q.delete();
        rst            = 1'b1;
        bus.enable     = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 16'h0000;
        #1;
        check(name, sample(), rst_exp);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_scan = 1'b0;
        m_t    = 0;
        m_buf  = 16'h0000;
        m_shad = 16'h0000;
        m_pend = 1'b0;
        sb_on  = 1'b1;
    endtask

    initial begin
        obs_t ex;
        forever begin
            @(negedge clk);
            if (sb_on && exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                check("scan", sample(), ex);
            end
        end
    end

    initial begin
        logic        lv;
        logic [15:0] ld;
        bit          first;

        do_reset("reset_init");

        // Idle preload, then a frame with a mid-frame load followed by a stalled second offer.
        do_cycle(1'b0, 1'b1, 16'hFA9C);
        do_cycle(1'b0, 1'b0, 16'h0000);
        do_cycle(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3 * F; i++) begin
            lv = m_scan && (m_t >= P) && (m_t < F);
            ld = (m_t == P) ? 16'h8888 : 16'h1234;
            do_cycle(1'b1, lv, ld);
        end

        for (int i = 0; i < 600; i++) begin
            do_cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) == 0), 16'($urandom));
        end

        // Offers placed exactly on frame-boundary cycles.
        first = 1'b1;
        for (int i = 0; i < 3 * F + 2; i++) begin
            lv = m_scan && ((m_t % F) == F - 1);
            ld = first ? 16'h9ABC : 16'($urandom);
            if (lv) first = 1'b0;
            do_cycle(1'b1, lv, ld);
        end

        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        #2;
        do_reset("reset_mid");

        for (int i = 0; i < 200; i++) begin
            do_cycle(($urandom_range(0, 29) != 0), ($urandom_range(0, 2) == 0), 16'($urandom));
        end
        do_cycle(1'b0, 1'b0, 16'h0000);
        do_cycle(1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
